// File: rtl/jt12_mixn_if.sv
// Bus bundle for the N-channel stereo mixer: the sample inputs, the shadowed
// controls and the mixed stereo result with its strobes.
interface jt12_mixn_if #(
  parameter int CH = 4,
  parameter int W  = 16,
  parameter int GW = 8,
  parameter int OW = 16
);
  logic                 cen;
  logic                 in_sample;
  logic [CH*W-1:0]      in_l;
  logic [CH*W-1:0]      in_r;
  logic [CH*GW-1:0]     gain;
  logic [CH-1:0]        mute;
  logic signed [OW-1:0] snd_left;
  logic signed [OW-1:0] snd_right;
  logic                 snd_sample;
  logic                 clip_l;
  logic                 clip_r;
  logic                 overrun;

  modport master (
    output cen, in_sample, in_l, in_r, gain, mute,
    input  snd_left, snd_right, snd_sample, clip_l, clip_r, overrun
  );

  modport slave (
    input  cen, in_sample, in_l, in_r, gain, mute,
    output snd_left, snd_right, snd_sample, clip_l, clip_r, overrun
  );
endinterface

// File: rtl/jt12_mixn.sv
// N-channel stereo mixer: captures one stereo sample per source, accumulates
// gain-scaled channels serially (one per cen edge), then emits a saturated
// stereo result with a one-clk strobe.
module jt12_mixn #(
  parameter int CH = 4,
  parameter int W  = 16,
  parameter int GW = 8,
  parameter int OW = 16
) (
  input  logic        clk,
  input  logic        rst,
  jt12_mixn_if.slave  bus
);
  // Channel index width; accumulator growth bits (one spare when CH=1 keeps
  // the replication counts legal).
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int CB = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = W + GW + 1;
  localparam int AW = PW + CB;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [CH*W-1:0]      sh_l_q, sh_r_q;
  logic [CH*GW-1:0]     sh_gain_q;
  logic [CH-1:0]        sh_mute_q;
  logic signed [OW-1:0] snd_left_q, snd_right_q;
  logic                 clip_l_q, clip_r_q, snd_sample_q, overrun_q;
  logic                 capture, load_out, snd_sample_d, overrun_d;

  // Per-channel views of the shadow copies.
  logic signed [W-1:0]  sh_l_arr [CH];
  logic signed [W-1:0]  sh_r_arr [CH];
  logic [GW-1:0]        sh_g_arr [CH];

  for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
    assign sh_l_arr[gi] = sh_l_q[gi*W +: W];
    assign sh_r_arr[gi] = sh_r_q[gi*W +: W];
    assign sh_g_arr[gi] = sh_gain_q[gi*GW +: GW];
  end

  // Signed product of the selected channel; gain is zero-extended so it is
  // never interpreted as negative.
  logic signed [PW-1:0] prod_l, prod_r, gain_ext;
  logic signed [AW-1:0] prod_l_ext, prod_r_ext;

  assign gain_ext   = $signed({{(W+1){1'b0}}, sh_g_arr[idx_q]});
  assign prod_l     = $signed({{(GW+1){sh_l_arr[idx_q][W-1]}}, sh_l_arr[idx_q]}) * gain_ext;
  assign prod_r     = $signed({{(GW+1){sh_r_arr[idx_q][W-1]}}, sh_r_arr[idx_q]}) * gain_ext;
  assign prod_l_ext = {{CB{prod_l[PW-1]}}, prod_l};
  assign prod_r_ext = {{CB{prod_r[PW-1]}}, prod_r};

  // Remove the unity-gain scaling; arithmetic shift floors toward -inf.
  logic signed [AW-1:0] res_l, res_r;
  logic signed [OW-1:0] sat_l, sat_r;
  logic                 sat_clip_l, sat_clip_r;

  assign res_l = acc_l_q >>> (GW-1);
  assign res_r = acc_r_q >>> (GW-1);

  // Clamp both scaled sums to the output range and flag any clamping.
  always_comb begin
    sat_l      = res_l[OW-1:0];
    sat_r      = res_r[OW-1:0];
    sat_clip_l = 1'b0;
    sat_clip_r = 1'b0;
    if (res_l > SAT_MAX) begin
      sat_l = SAT_MAX[OW-1:0];  sat_clip_l = 1'b1;
    end else if (res_l < SAT_MIN) begin
      sat_l = SAT_MIN[OW-1:0];  sat_clip_l = 1'b1;
    end
    if (res_r > SAT_MAX) begin
      sat_r = SAT_MAX[OW-1:0];  sat_clip_r = 1'b1;
    end else if (res_r < SAT_MIN) begin
      sat_r = SAT_MIN[OW-1:0];  sat_clip_r = 1'b1;
    end
  end

  // Next-state logic: capture in IDLE, one channel per cen in ACC, publish in OUT.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_l_d      = acc_l_q;
    acc_r_d      = acc_r_q;
    capture      = 1'b0;
    load_out     = 1'b0;
    snd_sample_d = 1'b0;
    overrun_d    = 1'b0;
    if (bus.cen) begin
      case (state_q)
        IDLE: begin
          if (bus.in_sample) begin
            capture = 1'b1;
            acc_l_d = '0;
            acc_r_d = '0;
            idx_d   = '0;
            state_d = ACC;
          end
        end
        ACC: begin
          overrun_d = bus.in_sample;
          if (!sh_mute_q[idx_q]) begin
            acc_l_d = acc_l_q + prod_l_ext;
            acc_r_d = acc_r_q + prod_r_ext;
          end
          if (idx_q == IW'(CH-1)) begin
            idx_d   = '0;
            state_d = OUT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        OUT: begin
          overrun_d    = bus.in_sample;
          load_out     = 1'b1;
          snd_sample_d = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state, accumulators and one-clk strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      snd_sample_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      snd_sample_q <= snd_sample_d;
      overrun_q    <= overrun_d;
    end
  end

  // Shadow copies of the inputs and the held output sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      sh_gain_q   <= '0;
      sh_mute_q   <= '0;
      snd_left_q  <= '0;
      snd_right_q <= '0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
    end else begin
      if (capture) begin
        sh_l_q    <= bus.in_l;
        sh_r_q    <= bus.in_r;
        sh_gain_q <= bus.gain;
        sh_mute_q <= bus.mute;
      end
      if (load_out) begin
        snd_left_q  <= sat_l;
        snd_right_q <= sat_r;
        clip_l_q    <= sat_clip_l;
        clip_r_q    <= sat_clip_r;
      end
    end
  end

  assign bus.snd_left   = snd_left_q;
  assign bus.snd_right  = snd_right_q;
  assign bus.snd_sample = snd_sample_q;
  assign bus.clip_l     = clip_l_q;
  assign bus.clip_r     = clip_r_q;
  assign bus.overrun    = overrun_q;
endmodule
